aux_cmd_engine: RTL
===================

AUX_CMD_ENGINE -- requirements
Module: aux_cmd_engine

Interface
REQ-001 Parameter: ACK_TIMEOUT, default 8'd255, register-bus ack timeout in clk cycles.
REQ-002 Port: clk  in  1  single clock for all logic.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: aux_read_req  out  1  one-cycle pulse requesting one word from the aux_io input FIFO.
REQ-005 Port: aux_write_req  out  1  one-cycle pulse requesting that aux_data_write be pushed to the aux_io output FIFO.
REQ-006 Port: aux_data_write  out  32  response word to the host.
REQ-007 Port: aux_data_read  in  32  command word from the host; valid when aux_busy falls after a read.
REQ-008 Port: aux_busy  in  1  aux_io busy; rises the cycle after a request and falls on completion.
REQ-009 Port: reg_addr  out  16  register-bus address.
REQ-010 Port: reg_wdata  out  32  register-bus write data.
REQ-011 Port: reg_we / reg_re  out  1 each  one-cycle write or read strobe.
REQ-012 Port: reg_rdata  in  32  read data; valid with reg_ack.
REQ-013 Port: reg_ack  in  1  one-cycle completion from the register slave.
REQ-014 Port: cmd_count  out  16  count of completed commands.
REQ-015 Port: err_flag  out  1  sticky error flag.

Function
REQ-016 Header word format SHALL be: [31:30] opcode (00 NOP, 01 WRITE, 10 READ, 11 illegal); [29:16] ignored; [15:0] address.
REQ-017 States SHALL be: IDLE, RD_HDR, WT_HDR, DECODE, RD_DAT, WT_DAT, REG_OP, WT_ACK, WR_RSP, WT_RSP, WR_DAT, WT_DAT2.
REQ-018 Every aux request SHALL be a single-cycle pulse.
REQ-019 After any aux request, the FSM SHALL skip one cycle, then wait in the WT_* state until aux_busy==0.
REQ-020 IDLE SHALL move to RD_HDR unconditionally on the cycle after reset is released.
REQ-021 RD_HDR SHALL pulse aux_read_req; WT_HDR SHALL latch aux_data_read into the header register on busy low.
REQ-022 DECODE, NOP: SHALL return to RD_HDR with no response and no count increment.
REQ-023 DECODE, illegal opcode: SHALL set the error bit and go to WR_RSP.
REQ-024 DECODE, WRITE: SHALL go to RD_DAT, fetch one data word, then go to REG_OP.
REQ-025 DECODE, READ: SHALL go directly to REG_OP.
REQ-026 REG_OP SHALL drive reg_addr=hdr[15:0] and pulse reg_we (with reg_wdata) or reg_re for exactly one cycle, then enter WT_ACK.
REQ-027 reg_addr and reg_wdata SHALL hold stable until exit from WT_ACK.
REQ-028 WT_ACK SHALL latch reg_rdata on reg_ack, then go to WR_RSP.
REQ-029 reg_ack asserted in the same cycle as the strobe SHALL be ignored; acks are accepted only in WT_ACK.
REQ-030 Response word SHALL be: [31:30] opcode echo; [29] error; [28:16] zero; [15:0] address.
REQ-031 WR_RSP SHALL pulse aux_write_req with the response word.
REQ-032 For READ, WR_DAT SHALL then send the read data, or 32'h0 if the error bit is set.
REQ-033 cmd_count SHALL increment by 1 when the last response word completes, wrapping from 16'hFFFF to 0.
REQ-034 err_flag SHALL set on any error and clear only on reset.
REQ-035 aux_data_write SHALL hold its value from the request until aux_busy falls.

Reset
REQ-036 On reset assertion, the FSM SHALL enter IDLE asynchronously.
REQ-037 Reset values: all strobes and requests 0; reg_addr, reg_wdata, aux_data_write, header and data registers 0; cmd_count 0; err_flag 0.
REQ-038 Reset mid-command SHALL abandon the command with no response emitted.

Configuration
REQ-039 Macro AUX_CMD_ACK_TIMEOUT_EN SHALL control the register-ack timeout.
REQ-040 With AUX_CMD_ACK_TIMEOUT_EN defined: an 8-bit counter SHALL run in WT_ACK; reaching ACK_TIMEOUT without reg_ack SHALL set the error bit and go to WR_RSP.
REQ-041 With AUX_CMD_ACK_TIMEOUT_EN undefined: WT_ACK SHALL wait indefinitely and the counter SHALL not exist.

Verification
REQ-042 Write test: host sends 32'h4000_0012 then 32'hCAFE_F00D. Expect one reg_we with addr 0x0012 and wdata 32'hCAFE_F00D. Slave acks after 3 cycles. Expect response 32'h4000_0012 and cmd_count=1.
REQ-043 Read test: host sends 32'h8000_0034; slave returns 32'h1234_5678 after 5 cycles. Expect responses 32'h8000_0034 then 32'h1234_5678.
REQ-044 Illegal/NOP test: send 32'hC000_0001 then 32'h0000_0000. Expect one response 32'hE000_0001, err_flag=1, cmd_count=1, and no register strobe.
REQ-045 Timeout test (AUX_CMD_ACK_TIMEOUT_EN defined): read 0x0005 with no ack. After 255 cycles expect 32'hA000_0005 then 32'h0. A late ack arriving afterwards SHALL be ignored.
REQ-046 Reset/backpressure test: keep aux_busy high 50 cycles on the response. Expect aux_data_write stable and no repeated aux_write_req. Then assert reset in WT_ACK; expect all outputs 0 and a fresh RD_HDR after release.

Source files
------------

// File: rtl/aux_cmd_engine.sv
// aux_cmd_engine: executes host command words from aux_io on the register bus and returns responses.
// Define AUX_CMD_ACK_TIMEOUT_EN to bound the wait for reg_ack to ACK_TIMEOUT cycles.
module aux_cmd_engine #(
    parameter logic [7:0] ACK_TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        reset,
    output logic        aux_read_req,
    output logic        aux_write_req,
    output logic [31:0] aux_data_write,
    input  logic [31:0] aux_data_read,
    input  logic        aux_busy,
    output logic [15:0] reg_addr,
    output logic [31:0] reg_wdata,
    output logic        reg_we,
    output logic        reg_re,
    input  logic [31:0] reg_rdata,
    input  logic        reg_ack,
    output logic [15:0] cmd_count,
    output logic        err_flag
);
    typedef enum logic [3:0] {
        IDLE, RD_HDR, WT_HDR, DECODE, RD_DAT, WT_DAT,
        REG_OP, WT_ACK, WR_RSP, WT_RSP, WR_DAT, WT_DAT2
    } state_t;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_RD  = 2'b10;

    state_t      state;
    logic [1:0]  hdr_op;
    logic [15:0] hdr_addr;
    logic [31:0] data_reg;
    logic        err;
    logic        skip;
    logic        aux_done;
    logic        ack_tmo;

    // skip masks the cycle right after a request, before aux_busy has risen
    assign aux_done = !skip && !aux_busy;

`ifdef AUX_CMD_ACK_TIMEOUT_EN
    logic [7:0] ack_cnt;

    assign ack_tmo = !reg_ack && ack_cnt == ACK_TIMEOUT - 8'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ack_cnt <= '0;
        else       ack_cnt <= state == WT_ACK ? ack_cnt + 8'd1 : '0;
    end
`else
    logic unused_ack_timeout;

    assign unused_ack_timeout = ^ACK_TIMEOUT;
    assign ack_tmo = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            aux_read_req   <= 1'b0;
            aux_write_req  <= 1'b0;
            aux_data_write <= '0;
            reg_addr       <= '0;
            reg_wdata      <= '0;
            reg_we         <= 1'b0;
            reg_re         <= 1'b0;
            cmd_count      <= '0;
            err_flag       <= 1'b0;
            hdr_op         <= '0;
            hdr_addr       <= '0;
            data_reg       <= '0;
            err            <= 1'b0;
            skip           <= 1'b0;
        end else begin
            aux_read_req  <= 1'b0;
            aux_write_req <= 1'b0;
            reg_we        <= 1'b0;
            reg_re        <= 1'b0;
            skip          <= 1'b0;
            case (state)
                IDLE: begin
                    state        <= RD_HDR;
                    aux_read_req <= 1'b1;
                end
                RD_HDR: begin
                    state <= WT_HDR;
                    skip  <= 1'b1;
                end
                WT_HDR: if (aux_done) begin
                    hdr_op   <= aux_data_read[31:30];
                    hdr_addr <= aux_data_read[15:0];
                    err      <= 1'b0;
                    state    <= DECODE;
                end
                DECODE: case (hdr_op)
                    OP_NOP: begin
                        state        <= RD_HDR;
                        aux_read_req <= 1'b1;
                    end
                    OP_WR: begin
                        state        <= RD_DAT;
                        aux_read_req <= 1'b1;
                    end
                    OP_RD: begin
                        state    <= REG_OP;
                        reg_re   <= 1'b1;
                        reg_addr <= hdr_addr;
                    end
                    default: begin
                        err            <= 1'b1;
                        err_flag       <= 1'b1;
                        state          <= WR_RSP;
                        aux_write_req  <= 1'b1;
                        aux_data_write <= {hdr_op, 1'b1, 13'b0, hdr_addr};
                    end
                endcase
                RD_DAT: begin
                    state <= WT_DAT;
                    skip  <= 1'b1;
                end
                WT_DAT: if (aux_done) begin
                    data_reg  <= aux_data_read;
                    reg_wdata <= aux_data_read;
                    reg_addr  <= hdr_addr;
                    reg_we    <= 1'b1;
                    state     <= REG_OP;
                end
                REG_OP: state <= WT_ACK;
                WT_ACK: if (reg_ack || ack_tmo) begin
                    state          <= WR_RSP;
                    aux_write_req  <= 1'b1;
                    aux_data_write <= {hdr_op, err | ack_tmo, 13'b0, hdr_addr};
                    data_reg       <= reg_ack ? reg_rdata : data_reg;
                    err            <= err | ack_tmo;
                    err_flag       <= err_flag | ack_tmo;
                end
                WR_RSP: begin
                    state <= WT_RSP;
                    skip  <= 1'b1;
                end
                WT_RSP: if (aux_done) begin
                    if (hdr_op == OP_RD) begin
                        state          <= WR_DAT;
                        aux_write_req  <= 1'b1;
                        aux_data_write <= err ? 32'h0 : data_reg;
                    end else begin
                        cmd_count    <= cmd_count + 16'd1;
                        state        <= RD_HDR;
                        aux_read_req <= 1'b1;
                    end
                end
                WR_DAT: begin
                    state <= WT_DAT2;
                    skip  <= 1'b1;
                end
                WT_DAT2: if (aux_done) begin
                    cmd_count    <= cmd_count + 16'd1;
                    state        <= RD_HDR;
                    aux_read_req <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
